// File: rtl/conv_enc_packer.sv
`default_nettype none
// ============================================================================
// Module      : conv_enc_packer
// Description : Rate-1/2 convolutional encoder with zero-tail frame
//               termination, packing coded pairs LSB-first into OUT_W-bit
//               words delivered over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_enc_packer #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 8,
  parameter int             OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int NPAIR = OUT_W / 2;
  localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int BW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW    = (K > 2) ? $clog2(K - 1) : 1;

  localparam logic [0:0] S_DATA = 1'b0;
  localparam logic [0:0] S_TAIL = 1'b1;

  logic [0:0]       r_state;
  logic [K-2:0]     r_sr;
  logic [BW-1:0]    r_bit_cnt;
  logic [TW-1:0]    r_tail_cnt;
  logic [PW-1:0]    r_p;
  logic [OUT_W-1:0] r_pack;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_last;

  logic             w_stall;
  logic             w_in_ready;
  logic             w_fire;
  logic             w_b;
  logic [K-1:0]     w_r;
  logic             w_c0;
  logic             w_c1;
  logic             w_last_bit;
  logic             w_last_tail;
  logic             w_complete;
  logic [OUT_W-1:0] w_pack_next;

  // A pair is produced on every accepted info bit, or every unstalled tail cycle.
  assign w_stall     = r_out_valid & ~out_ready;
  assign w_in_ready  = (r_state == S_DATA) & ~w_stall;
  assign w_fire      = (r_state == S_DATA) ? (in_valid & w_in_ready) : ~w_stall;
  assign w_b         = (r_state == S_DATA) ? in_bit : 1'b0;
  assign w_r         = {w_b, r_sr};
  assign w_c0        = ^(w_r & G0);
  assign w_c1        = ^(w_r & G1);
  assign w_last_bit  = (r_state == S_DATA) && (r_bit_cnt == BW'(FRAME_LEN - 1));
  assign w_last_tail = (r_state == S_TAIL) && (r_tail_cnt == TW'(K - 2));
  // The final tail pair closes the word early, leaving upper bits zero.
  assign w_complete  = w_fire & ((r_p == PW'(NPAIR - 1)) | w_last_tail);
  assign w_pack_next = r_pack | (OUT_W'({w_c1, w_c0}) << {r_p, 1'b0});

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  // Encoder shift register and DATA/TAIL frame sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_DATA;
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
    end else if (w_fire) begin
      r_sr <= w_r[K-1:1];
      if (r_state == S_DATA) begin
        if (w_last_bit) begin
          r_bit_cnt <= '0;
          r_state   <= S_TAIL;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        if (w_last_tail) begin
          r_tail_cnt <= '0;
          r_state    <= S_DATA;
        end else begin
          r_tail_cnt <= r_tail_cnt + 1'b1;
        end
      end
    end
  end

  // Accumulate coded pairs into the pack register; restart on word completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pack <= '0;
      r_p    <= '0;
    end else if (w_fire) begin
      if (w_complete) begin
        r_pack <= '0;
        r_p    <= '0;
      end else begin
        r_pack <= w_pack_next;
        r_p    <= r_p + 1'b1;
      end
    end
  end

  // Output holding register: load on completion, drain on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_pack_next;
      r_out_last  <= w_last_tail;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_enc_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_conv_enc_packer
// Description : Self-checking bench: directed vector table, backpressure,
//               mid-frame reset, exact-fit word width and randomized frames
//               against a convolution-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_enc_packer;

  localparam int           K   = 3;
  localparam logic [K-1:0] G0  = 3'b111;
  localparam logic [K-1:0] G1  = 3'b101;
  localparam int           FL  = 8;
  localparam int           OW  = 16;
  localparam int           OW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_bit, in_ready;
  logic          out_valid, out_last, out_ready;
  logic [OW-1:0] out_data;

  logic           in_valid_b, in_bit_b, in_ready_b;
  logic           out_valid_b, out_last_b, out_ready_b;
  logic [OW2-1:0] out_data_b;

  conv_enc_packer #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  conv_enc_packer #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL), .OUT_W(OW2)) dut_b (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid_b), .in_bit(in_bit_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
    .out_ready(out_ready_b)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    logic [FL-1:0] bits;   // bits[0] is sent first
    logic [OW-1:0] w0;
    logic [OW-1:0] w1;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  word_t got_q[$];
  word_t exp_q[$];
  word_t got_b[$];
  bit    rand_rdy = 1'b0;
  bit    rand_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: coded stream by direct convolution over the zero-tailed frame,
  // then chopped into OW-bit words with zero padding on the last one.
  task automatic model_frame(input logic [FL-1:0] bits);
    bit cs[$];
    int nw;
    for (int i = 0; i < FL + K - 1; i++) begin
      bit c0, c1, x;
      c0 = 1'b0;
      c1 = 1'b0;
      for (int j = 0; j < K; j++) begin
        x  = (i - j >= 0 && i - j < FL) ? bits[i-j] : 1'b0;
        c0 = c0 ^ (G0[K-1-j] & x);
        c1 = c1 ^ (G1[K-1-j] & x);
      end
      cs.push_back(c0);
      cs.push_back(c1);
    end
    nw = (cs.size() + OW - 1) / OW;
    for (int w = 0; w < nw; w++) begin
      word_t wd;
      wd.data = '0;
      for (int k = 0; k < OW; k++)
        if (w * OW + k < cs.size()) wd.data[k] = cs[w*OW+k];
      wd.last = (w == nw - 1);
      exp_q.push_back(wd);
    end
  endtask

  // Capture each handshaken word; the transfer happens at the following edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back('{out_data, out_last});
    if (rst_n && out_valid_b && out_ready_b) got_b.push_back('{OW'(out_data_b), out_last_b});
  end

  // Stalled words must stay put and input must be blocked.
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("stall_valid_hold", 32'(out_valid), 32'd1);
      check("stall_data_hold", 32'(out_data), 32'(prev_data));
      check("stall_last_hold", 32'(out_last), 32'(prev_last));
    end
    if (rst_n && out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_bits(input bit bq[$]);
    int  wait_cnt;
    bit  done;
    for (int i = 0; i < bq.size(); i++) begin
      if (rand_vld) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_bit   = bq[i];
      done     = 1'b0;
      wait_cnt = 0;
      while (!done) begin
        @(negedge clk);
        done = in_ready;
        @(posedge clk); #1;
        if (!done) begin
          wait_cnt++;
          if (wait_cnt > 500) begin
            check("accept_timeout", 32'd0, 32'd1);
            done = 1'b1;
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("word_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic bits_to_q(input logic [FL-1:0] bits, output bit q[$]);
    q = {};
    for (int i = 0; i < FL; i++) q.push_back(bits[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[5];
    bit          bq[$];
    bit          ball[$];
    logic [OW-1:0] held;
    int          gap;
    int          t;
    int          acc;
    logic [FL-1:0] rb;

    tbl[0] = '{8'hFF, 16'h555B, 16'h000E};   // all ones
    tbl[1] = '{8'h01, 16'h0037, 16'h0000};   // impulse
    tbl[2] = '{8'h55, 16'h4447, 16'h0003};   // 1,0,1,0,...
    tbl[3] = '{8'h00, 16'h0000, 16'h0000};   // all zeros
    tbl[4] = '{8'h01, 16'h0037, 16'h0000};   // impulse again

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_bit_b = 1'b0; out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vector table, free-running output.
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      bits_to_q(tbl[v].bits, bq);
      send_bits(bq);
      gap = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (in_ready) break;
        gap++;
      end
      check("tail_gap", 32'(gap), 32'(K - 1));
      wait_words(2, 100);
      if (got_q.size() >= 2) begin
        check("vec_w0_data", 32'(got_q[0].data), 32'(tbl[v].w0));
        check("vec_w0_last", 32'(got_q[0].last), 32'd0);
        check("vec_w1_data", 32'(got_q[1].data), 32'(tbl[v].w1));
        check("vec_w1_last", 32'(got_q[1].last), 32'd1);
      end
      @(posedge clk); #1;
    end

    // Backpressure: hold the first word for 5 cycles.
    got_q.delete();
    bits_to_q(8'hFF, bq);
    fork
      send_bits(bq);
      begin
        t = 0;
        do begin
          @(posedge clk); #2;
          t++;
        end while (!out_valid && t < 200);
        check("bp_word_seen", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        held = out_data;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #2;
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_data", 32'(out_data), 32'(held));
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_words(2, 100);
    if (got_q.size() >= 2) begin
      check("bp_w0_data", 32'(got_q[0].data), 32'h555B);
      check("bp_w0_last", 32'(got_q[0].last), 32'd0);
      check("bp_w1_data", 32'(got_q[1].data), 32'h000E);
      check("bp_w1_last", 32'(got_q[1].last), 32'd1);
    end

    // Reset mid-frame after 3 accepted bits.
    got_q.delete();
    bq = '{1'b1, 1'b1, 1'b1};
    send_bits(bq);
    #2 rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_data", 32'(out_data), 32'd0);
      check("rst_mid_last", 32'(out_last), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bits_to_q(8'h01, bq);
    send_bits(bq);
    wait_words(2, 100);
    repeat (20) @(posedge clk);
    check("rst_word_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("rst_w0_data", 32'(got_q[0].data), 32'h0037);
      check("rst_w0_last", 32'(got_q[0].last), 32'd0);
      check("rst_w1_data", 32'(got_q[1].data), 32'h0000);
      check("rst_w1_last", 32'(got_q[1].last), 32'd1);
    end
    #1;

    // Random back-to-back frames with random valid and ready.
    got_q.delete();
    exp_q.delete();
    ball = {};
    for (int f = 0; f < 50; f++) begin
      rb = FL'($urandom);
      model_frame(rb);
      for (int i = 0; i < FL; i++) ball.push_back(rb[i]);
    end
    rand_rdy = 1'b1;
    rand_vld = 1'b1;
    send_bits(ball);
    wait_words(exp_q.size(), 5000);
    rand_rdy = 1'b0;
    rand_vld = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check("rnd_data", 32'(got_q[i].data), 32'(exp_q[i].data));
        check("rnd_last", 32'(got_q[i].last), 32'(exp_q[i].last));
      end
    end

    // Exact-fit word width on the second instance.
    got_b.delete();
    acc = 0;
    @(posedge clk); #1;
    in_valid_b = 1'b1;
    in_bit_b   = 1'b1;
    t = 0;
    while (acc < FL && t < 200) begin
      @(negedge clk);
      if (in_ready_b) acc++;
      @(posedge clk); #1;
      if (acc == FL) in_valid_b = 1'b0;
      t++;
    end
    in_valid_b = 1'b0;
    t = 0;
    while (got_b.size() < 5 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    check("fit_word_count", 32'(got_b.size()), 32'd5);
    if (got_b.size() >= 5) begin
      check("fit_w0", 32'(got_b[0].data), 32'hB);
      check("fit_w1", 32'(got_b[1].data), 32'h5);
      check("fit_w2", 32'(got_b[2].data), 32'h5);
      check("fit_w3", 32'(got_b[3].data), 32'h5);
      check("fit_w4", 32'(got_b[4].data), 32'hE);
      for (int i = 0; i < 5; i++)
        check("fit_last", 32'(got_b[i].last), (i == 4) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
